// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the serial boot loader.
package uart_loader_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_LEN,
      S_DATA,
      S_WRITE,
      S_CSUM
   } state_t;

   typedef enum logic [1:0] {
      ERR_ALIGN   = 2'd0,
      ERR_CSUM    = 2'd1,
      ERR_TIMEOUT = 2'd2,
      ERR_LINE    = 2'd3
   } err_code_t;

   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
   localparam int ADDR_BYTES = 4;
   localparam int LEN_BYTES  = 2;
   localparam int WORD_BYTES = 4;

endpackage

// File: rtl/uart_loader_timer.sv
// Inter-byte watchdog: reloads on clr, counts down while enabled, flags expiry at zero.
module uart_loader_timer #(
   parameter int WIDTH = 23
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [WIDTH-1:0] load_val,
   output logic             expired
);

   logic [WIDTH-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= load_val;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   // A byte arriving in the expiry cycle wins over the timeout.
   assign expired = en && !clr && (cnt == '0);

endmodule

// File: rtl/uart_loader.sv
// Parses framed load packets from the UART receiver and writes 32-bit words to memory,
// holding the core in reset while a packet is in progress. ADDR_WIDTH must be <= 32.
module uart_loader
   import uart_loader_pkg::*;
#(
   parameter int          ADDR_WIDTH     = 32,
   parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
   parameter int          TIMEOUT_CYCLES = 5_000_000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            i_data,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic                  i_frame_error,
   input  logic                  i_overrun_error,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   output logic [31:0]           o_mem_wdata,
   output logic                  o_mem_we,
   input  logic                  i_mem_ready,
   output logic                  o_cpu_rst,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_error,
   output logic [1:0]            o_err_code
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYCLES - 1);

   state_t                state;
   logic [1:0]            byte_cnt;
   logic [7:0]            csum;
   logic [31:0]           word;
   logic [31:0]           word_next;
   logic [ADDR_WIDTH-1:0] addr;
   logic [15:0]           remaining;
   logic                  accept;
   logic                  tmr_en;
   logic                  tmr_expired;
   logic                  abort;
   err_code_t             abort_code;

   assign accept    = i_valid && o_ready;
   assign word_next = {i_data, word[31:8]};
   assign tmr_en    = (state == S_ADDR) || (state == S_LEN) ||
                      (state == S_DATA) || (state == S_CSUM);

   uart_loader_timer #(
      .WIDTH(TW)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .clr      (accept),
      .en       (tmr_en),
      .load_val (TIMER_LOAD),
      .expired  (tmr_expired)
   );

   // Abort sources in priority order; line errors preempt a same-cycle byte.
   always_comb begin
      abort      = 1'b0;
      abort_code = ERR_ALIGN;
      if ((state != S_IDLE) && (i_frame_error || i_overrun_error)) begin
         abort      = 1'b1;
         abort_code = ERR_LINE;
      end else if (tmr_expired) begin
         abort      = 1'b1;
         abort_code = ERR_TIMEOUT;
      end else if (accept && (state == S_ADDR) && (byte_cnt == 2'(ADDR_BYTES - 1)) &&
                   (word_next[1:0] != 2'b00)) begin
         abort      = 1'b1;
         abort_code = ERR_ALIGN;
      end else if (accept && (state == S_CSUM) && (i_data != csum)) begin
         abort      = 1'b1;
         abort_code = ERR_CSUM;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         byte_cnt    <= '0;
         csum        <= '0;
         word        <= '0;
         addr        <= '0;
         remaining   <= '0;
         o_ready     <= 1'b1;
         o_mem_addr  <= '0;
         o_mem_wdata <= '0;
         o_mem_we    <= 1'b0;
         o_cpu_rst   <= 1'b0;
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
         o_error     <= 1'b0;
         o_err_code  <= '0;
      end else begin
         o_done  <= 1'b0;
         o_error <= 1'b0;
         if (abort) begin
            state      <= S_IDLE;
            o_error    <= 1'b1;
            o_err_code <= abort_code;
            o_busy     <= 1'b0;
            o_cpu_rst  <= 1'b0;
            o_mem_we   <= 1'b0;
            o_ready    <= 1'b1;
         end else begin
            case (state)
               S_IDLE: begin
                  if (accept && (i_data == SYNC_BYTE)) begin
                     state      <= S_ADDR;
                     o_busy     <= 1'b1;
                     o_cpu_rst  <= 1'b1;
                     o_err_code <= ERR_ALIGN;
                     csum       <= '0;
                     byte_cnt   <= '0;
                  end
               end
               S_ADDR: begin
                  if (accept) begin
                     csum     <= csum ^ i_data;
                     word     <= word_next;
                     byte_cnt <= byte_cnt + 1'b1;
                     if (byte_cnt == 2'(ADDR_BYTES - 1)) begin
                        addr     <= word_next[ADDR_WIDTH-1:0];
                        byte_cnt <= '0;
                        state    <= S_LEN;
                     end
                  end
               end
               S_LEN: begin
                  if (accept) begin
                     csum     <= csum ^ i_data;
                     word     <= word_next;
                     byte_cnt <= byte_cnt + 1'b1;
                     if (byte_cnt == 2'(LEN_BYTES - 1)) begin
                        remaining <= word_next[31:16];
                        byte_cnt  <= '0;
                        state     <= (word_next[31:16] != 16'd0) ? S_DATA : S_CSUM;
                     end
                  end
               end
               S_DATA: begin
                  if (accept) begin
                     csum     <= csum ^ i_data;
                     word     <= word_next;
                     byte_cnt <= byte_cnt + 1'b1;
                     if (byte_cnt == 2'(WORD_BYTES - 1)) begin
                        byte_cnt    <= '0;
                        state       <= S_WRITE;
                        o_mem_we    <= 1'b1;
                        o_mem_wdata <= word_next;
                        o_mem_addr  <= addr;
                        o_ready     <= 1'b0;
                     end
                  end
               end
               S_WRITE: begin
                  if (i_mem_ready) begin
                     o_mem_we  <= 1'b0;
                     o_ready   <= 1'b1;
                     addr      <= addr + ADDR_WIDTH'(4);
                     remaining <= remaining - 16'd1;
                     state     <= (remaining == 16'd1) ? S_CSUM : S_DATA;
                  end
               end
               S_CSUM: begin
                  if (accept) begin
                     o_done    <= 1'b1;
                     o_busy    <= 1'b0;
                     o_cpu_rst <= 1'b0;
                     state     <= S_IDLE;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader: good/bad packets, backpressure, aborts and reset.
module tb_uart_loader;

   logic        clk;
   logic        rst;
   logic [7:0]  i_data;
   logic        i_valid;
   logic        o_ready;
   logic        i_frame_error;
   logic        i_overrun_error;
   logic [31:0] o_mem_addr;
   logic [31:0] o_mem_wdata;
   logic        o_mem_we;
   logic        i_mem_ready;
   logic        o_cpu_rst;
   logic        o_busy;
   logic        o_done;
   logic        o_error;
   logic [1:0]  o_err_code;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          wr_cnt  = 0;
   logic [31:0] wr_addr [16];
   logic [31:0] wr_data [16];
   logic [7:0]  pkt [$];

   uart_loader #(
      .ADDR_WIDTH     (32),
      .SYNC_BYTE      (8'hA5),
      .TIMEOUT_CYCLES (100)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .i_data          (i_data),
      .i_valid         (i_valid),
      .o_ready         (o_ready),
      .i_frame_error   (i_frame_error),
      .i_overrun_error (i_overrun_error),
      .o_mem_addr      (o_mem_addr),
      .o_mem_wdata     (o_mem_wdata),
      .o_mem_we        (o_mem_we),
      .i_mem_ready     (i_mem_ready),
      .o_cpu_rst       (o_cpu_rst),
      .o_busy          (o_busy),
      .o_done          (o_done),
      .o_error         (o_error),
      .o_err_code      (o_err_code)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory-side log of accepted writes.
   always @(posedge clk) begin
      if (o_mem_we && i_mem_ready && !rst) begin
         if (wr_cnt < 16) begin
            wr_addr[wr_cnt] = o_mem_addr;
            wr_data[wr_cnt] = o_mem_wdata;
         end
         wr_cnt = wr_cnt + 1;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, observed hang expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      @(negedge clk);
      while (!o_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!o_ready) begin
         n_tests++;
         n_fail++;
         $display("FAIL ready_wait: observed o_ready 0 expected 1 within 100 cycles");
      end
      i_data  = b;
      i_valid = 1'b1;
      @(negedge clk);
      i_valid = 1'b0;
   endtask

   task automatic send_pkt();
      foreach (pkt[i]) send_byte(pkt[i]);
   endtask

   int base;
   int n_wait;
   logic ok;

   initial begin
      rst = 1'b1; i_data = 8'h00; i_valid = 1'b0;
      i_frame_error = 1'b0; i_overrun_error = 1'b0; i_mem_ready = 1'b1;
      repeat (3) @(negedge clk);

      check("rst_ready",   {31'd0, o_ready},    32'd1);
      check("rst_we",      {31'd0, o_mem_we},   32'd0);
      check("rst_addr",    o_mem_addr,          32'd0);
      check("rst_wdata",   o_mem_wdata,         32'd0);
      check("rst_busy",    {31'd0, o_busy},     32'd0);
      check("rst_cpu_rst", {31'd0, o_cpu_rst},  32'd0);
      check("rst_pulses",  {30'd0, o_done, o_error}, 32'd0);
      check("rst_code",    {30'd0, o_err_code}, 32'd0);
      rst = 1'b0;

      // Noise in IDLE is discarded, then a good single-word packet.
      send_byte(8'h3C);
      check("idle_noise_busy", {31'd0, o_busy}, 32'd0);
      base = wr_cnt;
      send_byte(8'hA5);
      check("sync_busy",    {31'd0, o_busy},    32'd1);
      check("sync_cpu_rst", {31'd0, o_cpu_rst}, 32'd1);
      pkt = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD};
      send_pkt();
      check("mid_cpu_rst", {31'd0, o_cpu_rst}, 32'd1);
      send_byte(8'hDE);
      send_byte(8'h22);
      check("good_done",    {31'd0, o_done},    32'd1);
      check("good_cpu_rst", {31'd0, o_cpu_rst}, 32'd0);
      check("good_code",    {30'd0, o_err_code}, 32'd0);
      @(negedge clk);
      check("good_done_pulse", {31'd0, o_done}, 32'd0);
      check("good_nwr",  wr_cnt - base, 32'd1);
      check("good_addr", wr_addr[base], 32'h0000_0100);
      check("good_data", wr_data[base], 32'hDEAD_BEEF);

      // Bad checksum: write still lands, error code 1 held afterwards.
      base = wr_cnt;
      pkt = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h23};
      send_pkt();
      check("bad_error", {31'd0, o_error},    32'd1);
      check("bad_done",  {31'd0, o_done},     32'd0);
      check("bad_code",  {30'd0, o_err_code}, 32'd1);
      check("bad_nwr",   wr_cnt - base,       32'd1);
      check("bad_data",  wr_data[base],       32'hDEAD_BEEF);
      repeat (3) @(negedge clk);
      check("bad_code_held", {30'd0, o_err_code}, 32'd1);

      // Two words at 0x200 with 10 cycles of memory backpressure on the first.
      base = wr_cnt;
      send_byte(8'hA5);
      check("sync_clears_code", {30'd0, o_err_code}, 32'd0);
      pkt = '{8'h00, 8'h02, 8'h00, 8'h00, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33};
      send_pkt();
      i_mem_ready = 1'b0;
      send_byte(8'h44);
      ok = 1'b1;
      for (int c = 0; c < 10; c++) begin
         if (!(o_mem_we === 1'b1 && o_ready === 1'b0 &&
               o_mem_addr === 32'h0000_0200 && o_mem_wdata === 32'h4433_2211)) ok = 1'b0;
         @(negedge clk);
      end
      check("bp_stable", {31'd0, ok}, 32'd1);
      check("bp_no_write", wr_cnt - base, 32'd0);
      i_mem_ready = 1'b1;
      pkt = '{8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
      send_pkt();
      check("bp_done",  {31'd0, o_done}, 32'd1);
      check("bp_nwr",   wr_cnt - base,   32'd2);
      check("bp_addr0", wr_addr[base],   32'h0000_0200);
      check("bp_data0", wr_data[base],   32'h4433_2211);
      check("bp_addr1", wr_addr[base+1], 32'h0000_0204);
      check("bp_data1", wr_data[base+1], 32'h8877_6655);

      // Misaligned address 0x102 aborts after the fourth address byte.
      base = wr_cnt;
      pkt = '{8'hA5, 8'h02, 8'h01, 8'h00, 8'h00};
      send_pkt();
      check("align_error", {31'd0, o_error},    32'd1);
      check("align_code",  {30'd0, o_err_code}, 32'd0);
      check("align_busy",  {31'd0, o_busy},     32'd0);

      // Zero-length packet: done with no writes.
      pkt = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
      send_pkt();
      check("zero_done", {31'd0, o_done}, 32'd1);
      check("zero_nwr",  wr_cnt - base,   32'd0);

      // Timeout after three address bytes: abort after 100 idle clocks.
      pkt = '{8'hA5, 8'h00, 8'h01, 8'h00};
      send_pkt();
      n_wait = 0;
      while (!o_error && n_wait < 300) begin
         @(negedge clk);
         n_wait++;
      end
      check("tmo_cycles", n_wait, 32'd100);
      check("tmo_code",   {30'd0, o_err_code}, 32'd2);
      check("tmo_busy",   {31'd0, o_busy},     32'd0);
      base = wr_cnt;
      pkt = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
      send_pkt();
      check("tmo_recover_done", {31'd0, o_done}, 32'd1);
      check("tmo_recover_nwr",  wr_cnt - base,   32'd1);

      // Line errors: ignored in IDLE, abort with code 3 mid-DATA.
      @(negedge clk);
      i_overrun_error = 1'b1;
      @(negedge clk);
      i_overrun_error = 1'b0;
      check("line_idle_ignored", {31'd0, o_error}, 32'd0);
      base = wr_cnt;
      pkt = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'hEF, 8'hBE};
      send_pkt();
      i_frame_error = 1'b1;
      @(negedge clk);
      i_frame_error = 1'b0;
      check("line_error", {31'd0, o_error},    32'd1);
      check("line_code",  {30'd0, o_err_code}, 32'd3);
      check("line_nwr",   wr_cnt - base,       32'd0);

      // Reset while a write is pending.
      i_mem_ready = 1'b0;
      pkt = '{8'hA5, 8'h00, 8'h03, 8'h00, 8'h00, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
      send_pkt();
      check("prerst_we",   {31'd0, o_mem_we}, 32'd1);
      check("prerst_addr", o_mem_addr,        32'h0000_0300);
      rst = 1'b1;
      @(negedge clk);
      check("mrst_we",     {31'd0, o_mem_we},   32'd0);
      check("mrst_ready",  {31'd0, o_ready},    32'd1);
      check("mrst_addr",   o_mem_addr,          32'd0);
      check("mrst_wdata",  o_mem_wdata,         32'd0);
      check("mrst_flags",  {28'd0, o_busy, o_cpu_rst, o_done, o_error}, 32'd0);
      check("mrst_code",   {30'd0, o_err_code}, 32'd0);
      rst = 1'b0;
      i_mem_ready = 1'b1;
      base = wr_cnt;
      pkt = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
      send_pkt();
      check("post_rst_done", {31'd0, o_done}, 32'd1);
      check("post_rst_nwr",  wr_cnt - base,   32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
